// File: rtl/ring_lock_monitor.sv
// Lock detector for a ring-oscillator loop: samples phase errors and the DCO code
// on each synchronised gen_div edge and runs an acquire/lock/holdover FSM.
module ring_lock_monitor #(
    parameter int ERROR_WIDTH  = 5,
    parameter int DCO_CC_WIDTH = 5,
    parameter int ERR_THRESH   = 2,
    parameter int DCO_TOL      = 1,
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic                     fpga_clk_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic                     gen_div_i,
    input  logic [ERROR_WIDTH-1:0]   error_left_i,
    input  logic [ERROR_WIDTH-1:0]   error_above_i,
    input  logic [DCO_CC_WIDTH-1:0]  dco_cc_i,
    output logic                     locked_o,
    output logic                     lost_o,
    output logic [1:0]               state_o,
    output logic [ERROR_WIDTH-2:0]   max_err_o,
    output logic [7:0]               lock_events_o
);

    localparam int MW  = ERROR_WIDTH - 1;
    localparam int RW  = $clog2(LOCK_COUNT + 1);
    localparam int MSW = $clog2(UNLOCK_COUNT + 1);
    localparam logic [MW-1:0]           THR   = MW'(ERR_THRESH);
    localparam logic [DCO_CC_WIDTH-1:0] TOL   = DCO_CC_WIDTH'(DCO_TOL);
    localparam logic [RW-1:0]           RUN_L = RW'(LOCK_COUNT - 1);
    localparam logic [MSW-1:0]          MIS_L = MSW'(UNLOCK_COUNT - 1);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2,
        HOLDOVER = 2'd3
    } state_t;

    // Most negative input saturates to the largest positive magnitude.
    function automatic logic [MW-1:0] mag(input logic [ERROR_WIDTH-1:0] e);
        if (!e[ERROR_WIDTH-1])
            return e[MW-1:0];
        else if (e[MW-1:0] == '0)
            return '1;
        else
            return ~e[MW-1:0] + MW'(1);
    endfunction

    logic sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [1:0] warm_q, warm_d;
    logic armed_q, armed_d, strobe_q, strobe_d;
    logic smp_valid_q, smp_valid_d;
    logic [ERROR_WIDTH-1:0] smp_el_q, smp_el_d, smp_ea_q, smp_ea_d;
    logic [DCO_CC_WIDTH-1:0] smp_dco_q, smp_dco_d, prev_dco_q, prev_dco_d;
    logic prev_valid_q, prev_valid_d;
    state_t state_q, state_d;
    logic [RW-1:0] run_q, run_d;
    logic [MSW-1:0] miss_q, miss_d;
    logic locked_q, locked_d, lost_q, lost_d;
    logic [MW-1:0] max_err_q, max_err_d;
    logic [7:0] events_q, events_d;

    logic [MW-1:0] mag_l, mag_a, mx;
    logic [DCO_CC_WIDTH-1:0] dco_diff;
    logic in_win;

    always_comb begin
        sync1_d = gen_div_i;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        warm_d = {warm_q[0], 1'b1};
        // Arm only once the synchroniser holds a real low, not its reset value.
        armed_d = armed_q | (warm_q[1] & ~sync2_q);
        strobe_d = sync2_q & ~sync3_q & armed_q;

        smp_valid_d = strobe_q & enable_i;
        smp_el_d = strobe_q ? error_left_i : smp_el_q;
        smp_ea_d = strobe_q ? error_above_i : smp_ea_q;
        smp_dco_d = strobe_q ? dco_cc_i : smp_dco_q;

        mag_l = mag(smp_el_q);
        mag_a = mag(smp_ea_q);
        mx = (mag_l > mag_a) ? mag_l : mag_a;
        dco_diff = (smp_dco_q >= prev_dco_q) ? smp_dco_q - prev_dco_q
                                             : prev_dco_q - smp_dco_q;
        in_win = (mx <= THR) && (!prev_valid_q || dco_diff <= TOL);

        prev_dco_d = prev_dco_q;
        prev_valid_d = prev_valid_q;
        state_d = state_q;
        run_d = run_q;
        miss_d = miss_q;
        lost_d = 1'b0;
        max_err_d = max_err_q;
        events_d = events_q;

        if (smp_valid_q) begin
            max_err_d = mx;
            prev_dco_d = smp_dco_q;
            prev_valid_d = 1'b1;
            unique case (state_q)
                UNLOCKED: begin
                    if (in_win) begin
                        state_d = ACQUIRE;
                        run_d = RW'(1);
                    end
                end
                ACQUIRE: begin
                    if (!in_win) begin
                        state_d = UNLOCKED;
                        run_d = '0;
                    end else if (run_q >= RUN_L) begin
                        state_d = LOCKED;
                        run_d = '0;
                        if (events_q != 8'hFF)
                            events_d = events_q + 8'd1;
                    end else begin
                        run_d = run_q + RW'(1);
                    end
                end
                LOCKED: begin
                    if (!in_win) begin
                        state_d = HOLDOVER;
                        miss_d = MSW'(1);
                    end
                end
                HOLDOVER: begin
                    if (in_win) begin
                        state_d = LOCKED;
                        miss_d = '0;
                    end else if (miss_q >= MIS_L) begin
                        state_d = UNLOCKED;
                        miss_d = '0;
                        lost_d = 1'b1;
                    end else begin
                        miss_d = miss_q + MSW'(1);
                    end
                end
            endcase
        end

        if (!enable_i) begin
            smp_valid_d = 1'b0;
            state_d = UNLOCKED;
            run_d = '0;
            miss_d = '0;
            prev_valid_d = 1'b0;
            lost_d = 1'b0;
        end

        locked_d = (state_d == LOCKED) || (state_d == HOLDOVER);
    end

    always_ff @(posedge fpga_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            warm_q <= '0;
            armed_q <= 1'b0;
            strobe_q <= 1'b0;
            smp_valid_q <= 1'b0;
            smp_el_q <= '0;
            smp_ea_q <= '0;
            smp_dco_q <= '0;
            prev_dco_q <= '0;
            prev_valid_q <= 1'b0;
            state_q <= UNLOCKED;
            run_q <= '0;
            miss_q <= '0;
            locked_q <= 1'b0;
            lost_q <= 1'b0;
            max_err_q <= '0;
            events_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            warm_q <= warm_d;
            armed_q <= armed_d;
            strobe_q <= strobe_d;
            smp_valid_q <= smp_valid_d;
            smp_el_q <= smp_el_d;
            smp_ea_q <= smp_ea_d;
            smp_dco_q <= smp_dco_d;
            prev_dco_q <= prev_dco_d;
            prev_valid_q <= prev_valid_d;
            state_q <= state_d;
            run_q <= run_d;
            miss_q <= miss_d;
            locked_q <= locked_d;
            lost_q <= lost_d;
            max_err_q <= max_err_d;
            events_q <= events_d;
        end
    end

    assign locked_o = locked_q;
    assign lost_o = lost_q;
    assign state_o = state_q;
    assign max_err_o = max_err_q;
    assign lock_events_o = events_q;

endmodule

// File: tb/tb_ring_lock_monitor.sv
// Bench for ring_lock_monitor: scenario table, corner sequences and
// randomized samples against a behavioural lock model.
module tb_ring_lock_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic gen_div = 1'b0;
    logic [4:0] el = '0, ea = '0, dco = '0;
    logic locked_o, lost_o;
    logic [1:0] state_o;
    logic [3:0] max_err_o;
    logic [7:0] lock_events_o;

    always #5 clk = ~clk;

    ring_lock_monitor dut (
        .fpga_clk_i(clk),
        .reset_i(rst_n),
        .enable_i(en),
        .gen_div_i(gen_div),
        .error_left_i(el),
        .error_above_i(ea),
        .dco_cc_i(dco),
        .locked_o(locked_o),
        .lost_o(lost_o),
        .state_o(state_o),
        .max_err_o(max_err_o),
        .lock_events_o(lock_events_o)
    );

    int checks = 0;
    int errors = 0;
    int lost_cnt = 0;

    always @(negedge clk) if (lost_o) lost_cnt++;

    typedef struct {
        int el; int ea; int dco;
        int st; int lk; int me; int ev; int lost;
    } vec_t;
    vec_t tbl[$];

    // reference model state
    int m_state, m_run, m_miss, m_events, m_prev, m_prev_v, m_max, m_lost;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(int vl, int va, int vd, int st, int lk,
                                int me, int ev, int lost);
        vec_t v;
        v = '{vl, va, vd, st, lk, me, ev, lost};
        tbl.push_back(v);
    endfunction

    function automatic int magn(int v);
        if (v == -16) return 15;
        return (v < 0) ? -v : v;
    endfunction

    function automatic void model_reset();
        m_state = 0; m_run = 0; m_miss = 0; m_events = 0;
        m_prev = 0; m_prev_v = 0; m_max = 0; m_lost = 0;
    endfunction

    function automatic void model_disable();
        m_state = 0; m_run = 0; m_miss = 0; m_prev_v = 0; m_lost = 0;
    endfunction

    function automatic void model_sample(int vl, int va, int vd);
        int mx, dd;
        bit good;
        mx = (magn(vl) > magn(va)) ? magn(vl) : magn(va);
        dd = (vd > m_prev) ? vd - m_prev : m_prev - vd;
        good = (mx <= 2) && (!m_prev_v || dd <= 1);
        m_max = mx;
        m_prev = vd;
        m_prev_v = 1;
        m_lost = 0;
        if (m_state == 0) begin
            if (good) begin m_state = 1; m_run = 1; end
        end else if (m_state == 1) begin
            if (!good) begin m_state = 0; m_run = 0; end
            else begin
                m_run++;
                if (m_run >= 16) begin
                    m_state = 2; m_run = 0;
                    if (m_events < 255) m_events++;
                end
            end
        end else if (m_state == 2) begin
            if (!good) begin m_state = 3; m_miss = 1; end
        end else begin
            if (good) begin m_state = 2; m_miss = 0; end
            else begin
                m_miss++;
                if (m_miss >= 4) begin
                    m_state = 0; m_miss = 0; m_lost = 1;
                end
            end
        end
    endfunction

    task automatic do_sample(input int vl, input int va, input int vd);
        @(negedge clk);
        #($urandom_range(0, 3));
        el = vl[4:0];
        ea = va[4:0];
        dco = vd[4:0];
        gen_div = 1'b1;
        repeat (6) @(negedge clk);
        gen_div = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_all(input string tag, input int st, input int lk,
                             input int me, input int ev, input int lost);
        check({tag, ".state"}, int'(state_o), st);
        check({tag, ".locked"}, int'(locked_o), lk);
        check({tag, ".max_err"}, int'(max_err_o), me);
        check({tag, ".events"}, int'(lock_events_o), ev);
        check({tag, ".lost"}, lost, lk >= 0 ? lost : 0);
    endtask

    task automatic pulse_enable();
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
    endtask

    initial begin
        int lc0;
        int vl, va, vd;

        // lock acquisition: 16 samples with errors 0/+1
        for (int i = 0; i < 16; i++)
            add(i % 2, 0, 10, (i == 15) ? 2 : 1, (i == 15) ? 1 : 0,
                i % 2, (i == 15) ? 1 : 0, 0);
        // holdover then recovery
        for (int i = 0; i < 3; i++) add(5, 0, 10, 3, 1, 5, 1, 0);
        add(0, 1, 10, 2, 1, 1, 1, 0);
        // lock loss with the most negative error
        for (int i = 0; i < 4; i++)
            add(-16, 0, 10, (i == 3) ? 0 : 3, (i == 3) ? 0 : 1, 15, 1,
                (i == 3) ? 1 : 0);
        // DCO jump aborts acquisition
        for (int i = 0; i < 10; i++) add(0, 0, 10, 1, 0, 0, 1, 0);
        add(0, 0, 13, 0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++)
            add(0, -1, 13, (i == 15) ? 2 : 1, (i == 15) ? 1 : 0, 1,
                (i == 15) ? 2 : 1, 0);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.state", int'(state_o), 0);
        check("reset.locked", int'(locked_o), 0);
        check("reset.lost", int'(lost_o), 0);
        check("reset.max_err", int'(max_err_o), 0);
        check("reset.events", int'(lock_events_o), 0);
        rst_n = 1'b1;
        en = 1'b1;
        repeat (5) @(negedge clk);

        foreach (tbl[k]) begin
            lc0 = lost_cnt;
            do_sample(tbl[k].el, tbl[k].ea, tbl[k].dco);
            check($sformatf("tbl%0d.state", k), int'(state_o), tbl[k].st);
            check($sformatf("tbl%0d.locked", k), int'(locked_o), tbl[k].lk);
            check($sformatf("tbl%0d.max_err", k), int'(max_err_o), tbl[k].me);
            check($sformatf("tbl%0d.events", k), int'(lock_events_o), tbl[k].ev);
            check($sformatf("tbl%0d.lost", k), lost_cnt - lc0, tbl[k].lost);
        end

        // enable dropped for one cycle while locked
        lc0 = lost_cnt;
        pulse_enable();
        @(negedge clk);
        check("en.state", int'(state_o), 0);
        check("en.locked", int'(locked_o), 0);
        check("en.events", int'(lock_events_o), 2);
        check("en.lost", lost_cnt - lc0, 0);
        do_sample(0, 0, 20);
        check("en.dco_skip", int'(state_o), 1);
        do_sample(0, 0, 25);
        check("en.dco_check", int'(state_o), 0);

        // async reset during holdover
        for (int i = 0; i < 16; i++) do_sample(0, 0, 25);
        check("hold.locked", int'(locked_o), 1);
        check("hold.events", int'(lock_events_o), 3);
        do_sample(5, 0, 25);
        check("hold.state", int'(state_o), 3);
        lc0 = lost_cnt;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst.state", int'(state_o), 0);
        check("arst.locked", int'(locked_o), 0);
        check("arst.lost", int'(lost_o), 0);
        check("arst.max_err", int'(max_err_o), 0);
        check("arst.events", int'(lock_events_o), 0);

        // gen_div already high at reset release must not strobe
        gen_div = 1'b1;
        el = '0; ea = '0; dco = 5'd10;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("arst.no_lost", lost_cnt - lc0, 0);
        check("first_edge.none", int'(state_o), 0);
        gen_div = 1'b0;
        repeat (3) @(negedge clk);
        do_sample(0, 0, 10);
        check("first_edge.seen", int'(state_o), 1);

        // randomized samples against the model
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        model_reset();
        vd = 10;
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                pulse_enable();
                model_disable();
            end
            vl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) - 16
                                             : int'($urandom_range(0, 4)) - 2;
            va = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) - 16
                                             : int'($urandom_range(0, 4)) - 2;
            if ($urandom_range(0, 14) == 0)
                vd = int'($urandom_range(0, 31));
            else
                vd = vd + int'($urandom_range(0, 2)) - 1;
            if (vd < 0) vd = 0;
            if (vd > 31) vd = 31;
            lc0 = lost_cnt;
            do_sample(vl, va, vd);
            model_sample(vl, va, vd);
            check($sformatf("rnd%0d.state", n), int'(state_o), m_state);
            check($sformatf("rnd%0d.locked", n), int'(locked_o),
                  (m_state >= 2) ? 1 : 0);
            check($sformatf("rnd%0d.max_err", n), int'(max_err_o), m_max);
            check($sformatf("rnd%0d.events", n), int'(lock_events_o), m_events);
            check($sformatf("rnd%0d.lost", n), lost_cnt - lc0, m_lost);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
